signmag_split: RTL and testbench
================================

// Module: signmag_split
// PURPOSE
//  Splits a signed two's-complement fixed-point value into magnitude and sign; the
//  inverse of condneg (condneg(mag, neg) reproduces the input bit-exactly).
//  Two-stage pipeline with valid/ready handshake on both sides; sits in front of
//  unsigned datapaths (dividers, log, sqrt) that need |a| plus the sign to reapply.
// PARAMETERS
//  (none local)   -  all widths come from the fixedp interface: g.WIDTH = total bits
// PORTS
//  g.clk      in   1        clock (via fixedp interface g)
//  g.reset    in   1        asynchronous, active-high reset (via fixedp interface g)
//  a          in   WIDTH    signed two's-complement argument
//  in_valid   in   1        a is valid this cycle
//  in_ready   out  1        block accepts a this cycle
//  mag        out  WIDTH    unsigned magnitude |a|
//  neg        out  1        1 when a < 0
//  zero       out  1        1 when a == 0
//  out_valid  out  1        mag/neg/zero valid
//  out_ready  in   1        downstream accepts this cycle
// BEHAVIOUR
//  - Transfer on a port occurs when valid & ready are both 1 on a rising g.clk edge.
//  - Stage 1 (S1) registers a, neg = a[WIDTH-1], zero = (a == 0).
//    Stage 2 (S2) registers mag = neg ? (~a + 1) : a, carries neg/zero.
//  - Latency: 2 cycles from input transfer to out_valid with no stall; throughput 1/clk.
//  - Stall: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv;
//    in_ready = s1_adv (combinational from out_ready; no registered skid).
//  - A stage with valid=1 and no advance holds data unchanged; mag/neg/zero stable
//    while out_valid & !out_ready (AXI-style, no retraction).
//  - A bubble in S1 advancing into S2 clears s2_valid; data regs may keep old values.
//  - Width rule: mag is WIDTH-bit unsigned, so a = -2^(WIDTH-1) gives
//    mag = 2^(WIDTH-1) (MSB set, no saturation), neg=1. neg=0 for a=0 (no -0).
//  - Simultaneous in-transfer and out-transfer in the same cycle: both happen; full
//    pipe keeps streaming.
//  - Reset (async, any time): s1_valid=s2_valid=0, mag=0, neg=0, zero=0,
//    out_valid=0; in_ready=1 during and after reset. In-flight data is discarded;
//    no partial output after deassertion.
//  - in_valid while in reset is ignored.
// STRUCTURE
//  - No new package types; WIDTH comes from fixedp. Handshake rules match condneg-
//    family pipelines.
//  - One sub-module is natural: pipe_stage (valid/ready register slice, data width
//    parameter, async active-high reset), instantiated twice; negate logic between.
//  - Negation written as ~a + 1 in WIDTH bits (same rounding as condneg's -a).
// TESTING (WIDTH=16, out_ready=1 unless stated)
//  1. a=0xFFFB -> 2 clks later mag=0x0005, neg=1, zero=0, out_valid=1 for 1 clk.
//  2. a=0x8000 -> mag=0x8000, neg=1; a=0x0000 -> mag=0, neg=0, zero=1; a=0x7FFF -> 0x7FFF, neg=0.
//  3. Stream 0x0001..0x0008 back-to-back, out_ready=1010... -> all 8 out in order,
//     none lost/duplicated; in_ready=0 exactly when both stages full and out_ready=0.
//  4. out_ready=0 for 10 clks with 2 items queued -> mag/neg/zero frozen, in_ready=0;
//     release -> items emerge on consecutive clks.
//  5. Assert g.reset mid-stream (2 items in flight) -> out_valid=0, mag=0 immediately
//     (async); after release next input emerges with 2-clk latency, stale data never.
//  6. Random 10k signed values through signmag_split then condneg(mag, neg) ->
//     equals original a; zero == (a==0) for every item.

Source files
------------

// File: rtl/signmag_split_pkg.sv
// Shared width, data types and negate helper for the signmag_split pipeline.
package signmag_split_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] word_t;

    // Payload carried by both stages: the value (raw a, then |a|) plus sign and zero flags.
    typedef struct packed {
        word_t val;
        logic  neg;
        logic  zero;
    } split_t;

    localparam int SPLIT_W = $bits(split_t);

    // Two's-complement negation kept to WIDTH bits, so the most negative value maps to itself.
    function automatic word_t negate(input word_t x);
        return ~x + word_t'(1);
    endfunction

endpackage

// File: rtl/signmag_split_pipe_stage.sv
// Valid/ready register slice: advances when empty or when downstream accepts.
module signmag_split_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            out_valid <= 1'b0;
            // NOTE: the data register is reset as well so outputs read all-zero out of reset.
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // A bubble only clears valid; the data register keeps its stale contents.
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/signmag_split.sv
// Two-stage sign/magnitude splitter: S1 captures a with its flags, S2 holds |a|.
module signmag_split
    import signmag_split_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mag,
    output logic             neg,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    split_t s1_in, s1_out, s2_in, s2_out;
    logic   s1_valid;
    logic   s2_ready;

    assign s1_in.val  = a;
    assign s1_in.neg  = a[WIDTH-1];
    assign s1_in.zero = (a == '0);

    signmag_split_pipe_stage #(.DW(SPLIT_W)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    // Magnitude is WIDTH bits unsigned: -2^(WIDTH-1) comes out with only the MSB set.
    assign s2_in.val  = s1_out.neg ? negate(s1_out.val) : s1_out.val;
    assign s2_in.neg  = s1_out.neg;
    assign s2_in.zero = s1_out.zero;

    signmag_split_pipe_stage #(.DW(SPLIT_W)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign mag  = s2_out.val;
    assign neg  = s2_out.neg;
    assign zero = s2_out.zero;

endmodule

// File: tb/tb_signmag_split.sv
// Directed and randomised checks for signmag_split at WIDTH=16.
module tb_signmag_split;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mag;
    logic        neg;
    logic        zero;
    logic        out_valid;
    logic        out_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Reference occupancy model: what each stage should hold.
    logic        m1_v = 1'b0, m2_v = 1'b0;
    logic [15:0] m1_a = '0,  m2_a = '0;

    // Accepted outputs as {neg, zero, mag}.
    logic [17:0] got[$];

    signmag_split dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mag       (mag),
        .neg       (neg),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] abs16(input logic [15:0] x);
        return x[15] ? (16'd0 - x) : x;
    endfunction

    // One clock cycle: drive inputs, check at negedge, advance the model, return at posedge+1.
    task automatic step(input logic iv, input logic [15:0] av, input logic orr, output logic acc);
        logic e_ir;
        logic s2adv, s1adv;
        in_valid  = iv;
        a         = av;
        out_ready = orr;
        @(negedge clk);
        e_ir = !(m1_v && m2_v && !orr);
        vectors++;
        if (in_ready !== e_ir) begin
            miscompares++;
            $display("FAIL step_in_ready: got %b expected %b at %0t", in_ready, e_ir, $time);
        end
        vectors++;
        if (out_valid !== m2_v) begin
            miscompares++;
            $display("FAIL step_out_valid: got %b expected %b at %0t", out_valid, m2_v, $time);
        end
        if (m2_v) begin
            vectors++;
            if ({neg, zero, mag} !== {m2_a[15], (m2_a == 16'd0), abs16(m2_a)}) begin
                miscompares++;
                $display("FAIL step_output: got neg=%b zero=%b mag=%h expected neg=%b zero=%b mag=%h at %0t",
                         neg, zero, mag, m2_a[15], (m2_a == 16'd0), abs16(m2_a), $time);
            end
            if (orr)
                got.push_back({neg, zero, mag});
        end
        acc   = iv && e_ir;
        s2adv = !m2_v || orr;
        s1adv = !m1_v || s2adv;
        if (s2adv) begin
            m2_v = m1_v;
            if (m1_v) m2_a = m1_a;
        end
        if (s1adv) begin
            m1_v = iv;
            if (iv) m1_a = av;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        a         = 16'hFFFF;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, neg, zero, mag} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b neg=%b zero=%b mag=%h expected all zero",
                     out_valid, neg, zero, mag);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_valid: got %b expected 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic acc;
        step(1'b1, 16'hFFFB, 1'b1, acc);
        step(1'b0, 16'h0000, 1'b1, acc);
        vectors++;
        if ({out_valid, neg, zero, mag} !== {1'b1, 1'b1, 1'b0, 16'h0005}) begin
            miscompares++;
            $display("FAIL basic_fffb: got valid=%b neg=%b zero=%b mag=%h expected 1 1 0 0005",
                     out_valid, neg, zero, mag);
        end
        step(1'b0, 16'h0000, 1'b1, acc);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_one_clk: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_boundaries();
        logic acc;
        step(1'b1, 16'h8000, 1'b1, acc);
        step(1'b1, 16'h0000, 1'b1, acc);
        vectors++;
        if ({out_valid, neg, zero, mag} !== {1'b1, 1'b1, 1'b0, 16'h8000}) begin
            miscompares++;
            $display("FAIL bound_min: got valid=%b neg=%b zero=%b mag=%h expected 1 1 0 8000",
                     out_valid, neg, zero, mag);
        end
        step(1'b1, 16'h7FFF, 1'b1, acc);
        vectors++;
        if ({out_valid, neg, zero, mag} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL bound_zero: got valid=%b neg=%b zero=%b mag=%h expected 1 0 1 0000",
                     out_valid, neg, zero, mag);
        end
        step(1'b0, 16'h0000, 1'b1, acc);
        vectors++;
        if ({out_valid, neg, zero, mag} !== {1'b1, 1'b0, 1'b0, 16'h7FFF}) begin
            miscompares++;
            $display("FAIL bound_max: got valid=%b neg=%b zero=%b mag=%h expected 1 0 0 7fff",
                     out_valid, neg, zero, mag);
        end
        step(1'b0, 16'h0000, 1'b1, acc);
    endtask

    task automatic test_back_to_back();
        logic [15:0] nxt;
        logic        acc;
        int          cyc;
        nxt = 16'd1;
        cyc = 0;
        got.delete();
        while (got.size() < 8 && cyc < 40) begin
            step(nxt <= 16'd8, nxt, (cyc % 2) == 0, acc);
            if (acc) nxt++;
            cyc++;
        end
        vectors++;
        if (got.size() != 8) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d items expected 8", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== {2'b00, 16'(i + 1)}) begin
                miscompares++;
                $display("FAIL b2b_item%0d: got %h expected %h", i, got[i], {2'b00, 16'(i + 1)});
            end
        end
        got.delete();
    endtask

    task automatic test_stall();
        logic acc;
        step(1'b1, 16'hFFFF, 1'b0, acc);
        step(1'b1, 16'h0003, 1'b0, acc);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h1234, 1'b0, acc);
            vectors++;
            if ({out_valid, neg, zero, mag, in_ready} !== {1'b1, 1'b1, 1'b0, 16'h0001, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got valid=%b neg=%b zero=%b mag=%h in_ready=%b expected 1 1 0 0001 0",
                         i, out_valid, neg, zero, mag, in_ready);
            end
        end
        step(1'b0, 16'h0000, 1'b1, acc);
        vectors++;
        if ({out_valid, neg, zero, mag} !== {1'b1, 1'b0, 1'b0, 16'h0003}) begin
            miscompares++;
            $display("FAIL stall_release: got valid=%b neg=%b zero=%b mag=%h expected 1 0 0 0003",
                     out_valid, neg, zero, mag);
        end
        step(1'b0, 16'h0000, 1'b1, acc);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        logic acc;
        step(1'b1, 16'hFFF0, 1'b1, acc);
        step(1'b1, 16'h0042, 1'b1, acc);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({out_valid, neg, zero, mag, in_ready} !== {1'b0, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL midreset_async: got valid=%b neg=%b zero=%b mag=%h in_ready=%b expected 0 0 0 0000 1",
                     out_valid, neg, zero, mag, in_ready);
        end
        in_valid = 1'b1;
        a        = 16'h1111;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        m1_v     = 1'b0;
        m2_v     = 1'b0;
        step(1'b0, 16'h0000, 1'b1, acc);
        step(1'b0, 16'h0000, 1'b1, acc);
        step(1'b1, 16'hFF80, 1'b1, acc);
        step(1'b0, 16'h0000, 1'b1, acc);
        vectors++;
        if ({out_valid, neg, zero, mag} !== {1'b1, 1'b1, 1'b0, 16'h0080}) begin
            miscompares++;
            $display("FAIL midreset_after: got valid=%b neg=%b zero=%b mag=%h expected 1 1 0 0080",
                     out_valid, neg, zero, mag);
        end
        step(1'b0, 16'h0000, 1'b1, acc);
    endtask

    task automatic test_roundtrip();
        logic [15:0] sent[$];
        logic [15:0] av, orig, back;
        logic [17:0] item;
        logic        acc;
        int          bad = 0;
        got.delete();
        for (int i = 0; i < 10000; i++) begin
            av = 16'($urandom);
            step($urandom_range(0, 3) != 0, av, $urandom_range(0, 3) != 0, acc);
            if (acc) sent.push_back(av);
            while (got.size() > 0 && sent.size() > 0) begin
                item = got.pop_front();
                orig = sent.pop_front();
                back = item[17] ? (16'd0 - item[15:0]) : item[15:0];
                vectors++;
                if (back !== orig || item[16] !== (orig == 16'd0)) begin
                    miscompares++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL roundtrip: got condneg=%h zero=%b expected %h zero=%b",
                                 back, item[16], orig, (orig == 16'd0));
                end
            end
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, 16'h0000, 1'b1, acc);
        while (got.size() > 0 && sent.size() > 0) begin
            item = got.pop_front();
            orig = sent.pop_front();
            back = item[17] ? (16'd0 - item[15:0]) : item[15:0];
            vectors++;
            if (back !== orig || item[16] !== (orig == 16'd0)) begin
                miscompares++;
                $display("FAIL roundtrip_drain: got condneg=%h zero=%b expected %h", back, item[16], orig);
            end
        end
        vectors++;
        if (sent.size() != 0 || got.size() != 0) begin
            miscompares++;
            $display("FAIL roundtrip_count: got %0d unmatched outputs, %0d unmatched inputs expected 0 0",
                     got.size(), sent.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_roundtrip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
